// File: rtl/plot_capture_if.sv
// Pixel-plot bus from the drawers plus the frame dump stream back out.
// master = drawer/consumer side, slave = plot_capture.
interface plot_capture_if #(
    parameter int COLOUR_W = 3
);
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                dump_valid;
    logic                dump_ready;
    logic [7:0]          dump_x;
    logic [6:0]          dump_y;
    logic [COLOUR_W-1:0] dump_colour;
    logic                dump_done;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, dump_ready,
        input  dump_valid, dump_x, dump_y, dump_colour, dump_done
    );
    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, dump_ready,
        output dump_valid, dump_x, dump_y, dump_colour, dump_done
    );
endinterface

// File: rtl/plot_capture.sv
// Plot sink: captures plots into a WIDTH x HEIGHT frame store, counts them,
// and streams the frame back in raster order over a valid/ready port.
module plot_capture #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int COLOUR_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    plot_capture_if.slave bus,
    input  logic         clear_start,
    input  logic         dump_start,
    output logic         busy,
    output logic [15:0]  plot_count,
    output logic [7:0]   oob_count,
    output logic [7:0]   drop_count
);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [7:0]    X_LIM  = 8'(WIDTH);
    localparam logic [7:0]    X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0]    Y_LIM  = 7'(HEIGHT);
    localparam logic [6:0]    Y_LAST = 7'(HEIGHT - 1);
    localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, DUMP_RD, DUMP_OUT, DONE} state_t;

    state_t              state, state_nx;
    logic [COLOUR_W-1:0] mem [DEPTH];
    logic [AW-1:0]       clr_addr, plot_addr, rd_addr, wr_addr;
    logic [COLOUR_W-1:0] wr_data, rd_data;
    logic [7:0]          cur_x;
    logic [6:0]          cur_y;
    logic                in_range, plot_ok, plot_drop, plot_oob, wr_en, beat_ack, last_beat;

    assign in_range  = (bus.vga_x < X_LIM) && (bus.vga_y < Y_LIM);
    assign plot_ok   = bus.vga_plot && in_range && (state == IDLE);
    assign plot_drop = bus.vga_plot && in_range && (state != IDLE);
    assign plot_oob  = bus.vga_plot && !in_range;
    assign plot_addr = AW'(bus.vga_y) * AW'(WIDTH) + AW'(bus.vga_x);
    assign rd_addr   = AW'(cur_y) * AW'(WIDTH) + AW'(cur_x);
    assign beat_ack  = (state == DUMP_OUT) && bus.dump_ready;
    assign last_beat = (cur_x == X_LAST) && (cur_y == Y_LAST);

    // Single write port shared by clear sweep and plots; rst suppresses the write on its edge.
    assign wr_en   = !rst && ((state == CLEAR) || plot_ok);
    assign wr_addr = (state == CLEAR) ? clr_addr : plot_addr;
    assign wr_data = (state == CLEAR) ? '0 : bus.vga_colour;

    assign busy            = (state != IDLE);
    assign bus.dump_valid  = (state == DUMP_OUT);
    assign bus.dump_done   = (state == DONE);
    assign bus.dump_x      = cur_x;
    assign bus.dump_y      = cur_y;
    assign bus.dump_colour = rd_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (clear_start)     state_nx = CLEAR;
                else if (dump_start) state_nx = DUMP_RD;
            end
            CLEAR:    if (clr_addr == A_LAST) state_nx = IDLE;
            DUMP_RD:  state_nx = DUMP_OUT;
            DUMP_OUT: if (bus.dump_ready) state_nx = last_beat ? DONE : DUMP_RD;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr   <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            rd_data    <= '0;
            plot_count <= '0;
            oob_count  <= '0;
            drop_count <= '0;
        end else begin
            if (state == CLEAR) clr_addr <= (clr_addr == A_LAST) ? '0 : clr_addr + 1'b1;
            if (state == DUMP_RD) rd_data <= mem[rd_addr];
            // Raster walk; wraps back to (0,0) after the last beat so the next dump starts clean.
            if (beat_ack) begin
                if (cur_x == X_LAST) begin
                    cur_x <= '0;
                    cur_y <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
                end else begin
                    cur_x <= cur_x + 1'b1;
                end
            end
            if (plot_ok   && plot_count != '1) plot_count <= plot_count + 1'b1;
            if (plot_oob  && oob_count  != '1) oob_count  <= oob_count + 1'b1;
            if (plot_drop && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_plot_capture.sv
// Scoreboard bench for plot_capture: a frame model feeds expected dump beats
// into a queue that is drained as the DUT hands beats over.
module tb_plot_capture;
    localparam int W = 160;
    localparam int H = 120;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_start = 1'b0;
    logic        dump_start  = 1'b0;
    logic        busy;
    logic [15:0] plot_count;
    logic [7:0]  oob_count, drop_count;

    plot_capture_if #(.COLOUR_W(3)) bus();

    plot_capture #(.WIDTH(W), .HEIGHT(H), .COLOUR_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .clear_start(clear_start), .dump_start(dump_start),
        .busy(busy), .plot_count(plot_count),
        .oob_count(oob_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    beat_t      sb[$];
    logic [2:0] mem_m [W*H];
    int n_cmp = 0, n_err = 0;
    int m_plot = 0, m_oob = 0, m_drop = 0;
    int beats = 0, done_cnt = 0;
    bit no_dump = 1'b0, saw_valid = 1'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Negedge observation: handshake beats pop the queue, stalled beats must match the head.
    task automatic monitor();
        beat_t e;
        if (bus.dump_done === 1'b1) done_cnt++;
        if (bus.dump_valid === 1'b1) begin
            if (no_dump) saw_valid = 1'b1;
            if (sb.size() == 0) chk("beat_extra", 32'(bus.dump_valid), 0);
            else begin
                e = sb[0];
                chk(bus.dump_ready ? "beat" : "stall_hold",
                    32'({bus.dump_x, bus.dump_y, bus.dump_colour}), 32'({e.x, e.y, e.c}));
                if (bus.dump_ready === 1'b1) begin
                    void'(sb.pop_front());
                    beats++;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_plot(int x, int y, int c);
        bus.vga_x = 8'(x); bus.vga_y = 7'(y); bus.vga_colour = 3'(c); bus.vga_plot = 1'b1;
    endtask

    // Updates the model assuming the DUT is idle, then applies one plot cycle.
    task automatic plot_idle(int x, int y, int c);
        drive_plot(x, y, c);
        if (x < W && y < H) begin mem_m[y*W + x] = 3'(c); m_plot++; end
        else m_oob++;
        tick();
        bus.vga_plot = 1'b0;
    endtask

    task automatic push_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                sb.push_back('{8'(x), 7'(y), mem_m[y*W + x]});
    endtask

    task automatic chk_counts(string tag);
        chk({tag, "_plot"}, 32'(plot_count), m_plot);
        chk({tag, "_oob"},  32'(oob_count),  m_oob);
        chk({tag, "_drop"}, 32'(drop_count), m_drop);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        sb.delete();
        m_plot = 0; m_oob = 0; m_drop = 0;
    endtask

    initial begin
        int n;
        bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.vga_plot = 1'b0;
        bus.dump_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(bus.dump_valid), 0);
        chk("rst_done",  32'(bus.dump_done), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_xyc",   32'({bus.dump_x, bus.dump_y, bus.dump_colour}), 0);
        chk_counts("rst");

        // Full clear: busy for exactly W*H cycles
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 30000) begin n++; tick(); end
        chk("clr_busy_cycles", n, W*H);
        for (int i = 0; i < W*H; i++) mem_m[i] = '0;

        // Corner plots plus out-of-range plots that would alias onto the next row
        plot_idle(5, 7, 5);
        plot_idle(159, 119, 2);
        plot_idle(160, 0, 7);
        plot_idle(0, 120, 7);
        chk_counts("plots");

        // Full-speed dump
        push_frame();
        beats = 0; done_cnt = 0;
        bus.dump_ready = 1'b1;
        dump_start = 1'b1; tick(); dump_start = 1'b0;
        chk("lat_cyc1_valid", 32'(bus.dump_valid), 0);
        chk("dump_busy", 32'(busy), 1);
        tick();
        chk("lat_cyc2_valid", 32'(bus.dump_valid), 1);
        n = 0;
        while (sb.size() > 0 && n < 45000) begin n++; tick(); end
        chk("dump_drain", sb.size(), 0);
        repeat (4) tick();
        chk("dump_beats", beats, W*H);
        chk("dump_done_pulses", done_cnt, 1);
        chk("dump_end_busy", 32'(busy), 0);
        chk_counts("dump");

        // Stalled dump (ready 1-of-3), reset after beat 50
        push_frame();
        beats = 0;
        bus.dump_ready = 1'b0;
        dump_start = 1'b1; tick(); dump_start = 1'b0;
        n = 0;
        while (beats < 50 && n < 2000) begin
            bus.dump_ready = (n % 3 == 0);
            n++; tick();
        end
        chk("stall_reached50", 32'(beats >= 50), 1);
        bus.dump_ready = 1'b0;
        do_reset();
        chk("abort_valid", 32'(bus.dump_valid), 0);
        chk("abort_busy",  32'(busy), 0);
        chk_counts("abort");
        tick();
        chk("abort_idle_valid", 32'(bus.dump_valid), 0);

        // clear+dump+plot same cycle, then a plot and a dump request during CLEAR
        clear_start = 1'b1; dump_start = 1'b1; drive_plot(3, 3, 6); m_plot++;
        no_dump = 1'b1; saw_valid = 1'b0;
        tick();
        clear_start = 1'b0; dump_start = 1'b0; bus.vga_plot = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 30000) begin
            if (n == 100) begin drive_plot(5, 7, 7); m_drop++; end
            else bus.vga_plot = 1'b0;
            dump_start = (n == 200);
            n++; tick();
        end
        bus.vga_plot = 1'b0; dump_start = 1'b0;
        chk("clr2_busy_cycles", n, W*H);
        repeat (4) tick();
        no_dump = 1'b0;
        chk("clr2_no_dump", 32'(saw_valid), 0);
        chk_counts("clr2");
        for (int i = 0; i < W*H; i++) mem_m[i] = '0;

        // Pixels previously written (and the dropped plot) must read back as zero
        push_frame();
        beats = 0;
        bus.dump_ready = 1'b1;
        dump_start = 1'b1; tick(); dump_start = 1'b0;
        n = 0;
        while (beats < 1130 && n < 5000) begin n++; tick(); end
        chk("zero_reached", 32'(beats >= 1130), 1);
        bus.dump_ready = 1'b0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
